store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write queue between the MEM pipeline stage and the load/store memory wrapper (cache-backed data memory with LS_mode load extraction).
- Accepts stores from the pipeline in one cycle and drains them into the memory write port whenever no load needs that port.
- Detects load-after-store hazards against queued entries and stalls the load until the conflict clears.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, store data width.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- st_valid  input  1  pipeline presents a store.
- st_ready  output  1  store accepted this cycle; equals !full.
- st_addr  input  ADDR_WIDTH  store byte address.
- st_data  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_mode  input  3  `B_MODE, `H_MODE or `W_MODE, from the shared LS define header.
- ld_req  input  1  pipeline issues a load this cycle.
- ld_addr  input  ADDR_WIDTH  load byte address.
- ld_mode  input  3  load LS_mode.
- ld_stall  output  1  load must be held; combinational.
- mem_we  output  1  write strobe to the memory wrapper.
- mem_a  output  ADDR_WIDTH  write address (head entry).
- mem_wd  output  DATA_WIDTH  write data (head entry).
- mem_ls_mode  output  3  write mode (head entry).
- sb_empty  output  1  no entries queued; used by fence/ecall drain.
- misalign  output  1  registered one-cycle pulse: a store was dropped for misalignment.
- fwd_valid  output  1  load satisfied from buffer (feature only; tied 0 otherwise).
- fwd_data  output  DATA_WIDTH  forwarded word (feature only; tied 0 otherwise).

Behaviour:
- Reset: head, tail and count cleared to 0; all entry valid bits cleared; mem_we=0, misalign=0, sb_empty=1, fwd_valid=0. Reset takes effect on the clock edge at which rst=1 and discards any queued entries, including an entry being drained that cycle.
- Storage: circular FIFO; each entry holds addr, data and mode. Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide, range 0..DEPTH.
- Enqueue: on st_valid && st_ready, write the entry at tail and advance tail. st_ready = (count != DEPTH), computed from registered state only. When full and draining in the same cycle, the store is still refused and is accepted the following cycle.
- Misaligned store:
  - Condition: `H_MODE with st_addr[0]=1, or `W_MODE with st_addr[1:0]!=0.
  - The store is handshaken (st_ready honoured) but not enqueued.
  - misalign=1 on the next cycle only.
- Drain:
  - mem_we = !sb_empty && (!ld_req || ld_stall).
  - mem_a, mem_wd and mem_ls_mode are driven combinationally from the head entry.
  - The memory accepts every write in one cycle. When mem_we=1, head advances at the edge.
  - Latency: a store enqueued at edge N can drive mem_we no earlier than the cycle following edge N. There is no enqueue-to-memory bypass.
- Simultaneous enqueue and dequeue: count is unchanged; both pointers advance.
- Hazard: ld_stall = ld_req && any valid entry with addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]. The comparison is word-granular regardless of modes. A stalled load lets drain proceed, which guarantees forward progress.
- An entry being dequeued in the current cycle still counts for the hazard check in that cycle.
- sb_empty = (count == 0).
- Loads never enter the buffer. No response path exists other than ld_stall and the forwarding outputs.

Optional Feature:
- Macro: STB_FWD_EN.
- With STB_FWD_EN defined:
  - Scan valid entries from youngest (tail-1) to oldest and select the youngest word-address match.
  - If ld_mode==`W_MODE and the selected entry is `W_MODE: fwd_valid=1, fwd_data=entry data, and ld_stall=0 for that load. Older matching entries are ignored because the youngest full-word store supersedes them.
  - Any other match (sub-word on either side) gives ld_stall=1 and fwd_valid=0.
  - Forwarding is combinational in the same cycle as ld_req.
- Without STB_FWD_EN:
  - fwd_valid and fwd_data are constant 0.
  - Every match stalls.

Test Plan:
- Reset, then four `W_MODE stores to 0x100/0x104/0x108/0x10C with ld_req=0 -> mem_we asserted on four consecutive cycles starting one cycle after the first accept, addresses in order; sb_empty=1 afterwards.
- DEPTH=4, hold ld_req=1 to non-matching 0x200 and push five stores -> st_ready=0 on the fifth; release ld_req -> the fifth store is accepted the cycle after the first drain, never in the same cycle.
- Store `B_MODE 0x1003 data 0xAB, then ld_req `W_MODE 0x1000 -> ld_stall=1 until the entry is written; drain still occurs during the stall; ld_stall=0 on the cycle after mem_we.
- With STB_FWD_EN defined: stores `W_MODE 0x40=0x11111111 then 0x40=0x22222222 are queued; load `W_MODE 0x40 -> fwd_valid=1, fwd_data=0x22222222, ld_stall=0. Without the macro -> ld_stall=1, fwd_valid=0.
- Store `H_MODE to 0x301 -> not enqueued, misalign=1 for exactly one cycle, sb_empty unchanged.
- Three entries queued, assert rst for one cycle mid-drain -> next cycle count=0, mem_we=0, sb_empty=1, and no further writes reach the memory.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write queue between the MEM stage and the data memory write port, with
// word-granular load-after-store stall. Define STB_FWD_EN to forward full-word stores to loads.
`ifndef B_MODE
`define B_MODE 3'b000
`endif
`ifndef H_MODE
`define H_MODE 3'b001
`endif
`ifndef W_MODE
`define W_MODE 3'b010
`endif

module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [2:0]            st_mode,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_mode,
    output logic                  ld_stall,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [2:0]            mem_ls_mode,
    output logic                  sb_empty,
    output logic                  misalign,
    output logic                  fwd_valid,
    output logic [DATA_WIDTH-1:0] fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [2:0]            mode_q [DEPTH];
    logic [2:0]            mode_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  misalign_q, misalign_d;

    logic                  st_misaligned, enq, deq, hit;
    logic [DEPTH-1:0]      match;
    logic                  unused_bits;

    always_comb begin
        st_ready      = (count_q != CNT_W'(DEPTH));
        sb_empty      = (count_q == '0);
        st_misaligned = (st_mode == `H_MODE && st_addr[0]) ||
                        (st_mode == `W_MODE && st_addr[1:0] != 2'b00);
        enq           = st_valid && st_ready && !st_misaligned;
        // Entry being dequeued this cycle still has its valid bit set here.
        for (int i = 0; i < DEPTH; i++)
            match[i] = valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);
        hit = |match;
    end

`ifdef STB_FWD_EN
    logic             sel_found, fwd_hit;
    logic [PTR_W-1:0] sel_idx, idx;

    // Youngest-first scan: the most recent matching store decides forward vs stall.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = tail_q - PTR_W'(i);
            if (!sel_found && match[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
        fwd_hit = sel_found && (ld_mode == `W_MODE) && (mode_q[sel_idx] == `W_MODE);
    end

    assign fwd_valid   = ld_req && fwd_hit;
    assign fwd_data    = (ld_req && fwd_hit) ? data_q[sel_idx] : '0;
    assign ld_stall    = ld_req && hit && !fwd_hit;
    assign unused_bits = ^ld_addr[1:0];
`else
    assign fwd_valid   = 1'b0;
    assign fwd_data    = '0;
    assign ld_stall    = ld_req && hit;
    assign unused_bits = ^{ld_addr[1:0], ld_mode};
`endif

    always_comb begin
        mem_we      = !sb_empty && (!ld_req || ld_stall);
        mem_a       = addr_q[head_q];
        mem_wd      = data_q[head_q];
        mem_ls_mode = mode_q[head_q];
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        mode_d     = mode_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        deq        = mem_we;
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
            mode_d[tail_q]  = st_mode;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(enq) - CNT_W'(deq);
        misalign_d = st_valid && st_ready && st_misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload needs no reset; valid bits and count gate every use of it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        mode_q <= mode_d;
    end

    assign misalign = misalign_q;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized + directed bench for store_buffer against a queue-based reference model.
`ifndef B_MODE
`define B_MODE 3'b000
`endif
`ifndef H_MODE
`define H_MODE 3'b001
`endif
`ifndef W_MODE
`define W_MODE 3'b010
`endif

module tb_store_buffer;
    localparam int AW = 32, DW = 32, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, st_valid, st_ready, ld_req, ld_stall;
    logic [AW-1:0] st_addr, ld_addr, mem_a;
    logic [DW-1:0] st_data, mem_wd, fwd_data;
    logic [2:0]    st_mode, ld_mode, mem_ls_mode;
    logic          mem_we, sb_empty, misalign, fwd_valid;

    always #5 clk = ~clk;

    store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_mode(ld_mode), .ld_stall(ld_stall),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_ls_mode(mem_ls_mode),
        .sb_empty(sb_empty), .misalign(misalign), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] m; } ent_t;
    ent_t          q[$];
    bit            exp_mis = 1'b0;
    int            n_assert = 0, n_fail = 0, cyc = 0;
    int            we_cyc[$];
    logic [31:0]   we_addr[$];
    logic          o_ready, o_stall, o_we, o_fv, o_mis, o_empty;
    logic [31:0]   o_fd;
    int            acc_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit misal(input logic [2:0] m, input logic [31:0] a);
        return (m == `H_MODE && a[0]) || (m == `W_MODE && a[1:0] != 2'b00);
    endfunction

    // Model of the combinational outputs for the current inputs and queue contents.
    task automatic eval_exp(output bit ready, output bit stall, output bit fv,
                            output bit we, output logic [31:0] fd);
        int sel = -1;
        ready = (q.size() != DEPTH);
        for (int i = q.size() - 1; i >= 0; i--)
            if (sel < 0 && q[i].a[31:2] == ld_addr[31:2]) sel = i;
        fv = 1'b0; fd = '0; stall = 1'b0;
        if (ld_req && sel >= 0) begin
`ifdef STB_FWD_EN
            if (ld_mode == `W_MODE && q[sel].m == `W_MODE) begin
                fv = 1'b1;
                fd = q[sel].d;
            end else stall = 1'b1;
`else
            stall = 1'b1;
`endif
        end
        we = (q.size() > 0) && (!ld_req || stall);
    endtask

    task automatic tick();
        bit r = 1'b0, s = 1'b0, f = 1'b0, w = 1'b0, mis;
        logic [31:0] fd = '0;
        cyc++;
        @(negedge clk);
        o_ready = st_ready; o_stall = ld_stall; o_we = mem_we; o_fv = fwd_valid;
        o_fd = fwd_data; o_mis = misalign; o_empty = sb_empty;
        if (!rst) begin
            eval_exp(r, s, f, w, fd);
            check("st_ready", st_ready, r);
            check("ld_stall", ld_stall, s);
            check("fwd_valid", fwd_valid, f);
            check("fwd_data", fwd_data, fd);
            check("mem_we", mem_we, w);
            check("sb_empty", sb_empty, q.size() == 0);
            check("misalign", misalign, exp_mis);
            if (w) begin
                check("mem_a", mem_a, q[0].a);
                check("mem_wd", mem_wd, q[0].d);
                check("mem_ls_mode", mem_ls_mode, q[0].m);
            end
            if (mem_we) begin
                we_cyc.push_back(cyc);
                we_addr.push_back(mem_a);
            end
        end
        if (rst) begin
            q.delete();
            exp_mis = 1'b0;
        end else begin
            if (w) q.delete(0);
            mis = misal(st_mode, st_addr);
            exp_mis = st_valid && r && mis;
            if (st_valid && r && !mis) q.push_back('{st_addr, st_data, st_mode});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        st_valid = v; st_addr = a; st_data = d; st_mode = m;
    endtask

    task automatic set_ld(input bit v, input logic [31:0] a, input logic [2:0] m);
        ld_req = v; ld_addr = a; ld_mode = m;
    endtask

    initial begin
        rst = 1'b1;
        set_st(0, 0, 0, `W_MODE);
        set_ld(0, 0, `W_MODE);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        tick();
        check("rst_empty", o_empty, 1);
        check("rst_we", o_we, 0);
        check("rst_mis", o_mis, 0);
        check("rst_fv", o_fv, 0);

        // Four word stores drain back-to-back starting one cycle after the first accept
        we_cyc.delete(); we_addr.delete();
        acc_cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            set_st(1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), `W_MODE);
            tick();
        end
        set_st(0, 0, 0, `W_MODE);
        for (int i = 0; i < 3; i++) tick();
        check("t1_nwrites", we_cyc.size(), 4);
        if (we_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_wcyc", we_cyc[i], acc_cyc + 1 + i);
                check("t1_waddr", we_addr[i], 32'h100 + 32'(4 * i));
            end
        end
        check("t1_empty", o_empty, 1);

        // Full buffer refuses, and a drain does not free the slot in the same cycle
        set_ld(1, 32'h200, `W_MODE);
        for (int i = 0; i < 4; i++) begin
            set_st(1, 32'h10 + 32'(4 * i), 32'h5000_0000 + 32'(i), `W_MODE);
            tick();
        end
        set_st(1, 32'h20, 32'h5555_5555, `W_MODE);
        tick();
        check("t2_full", o_ready, 0);
        set_ld(0, 0, `W_MODE);
        tick();
        check("t2_drain", o_we, 1);
        check("t2_same_cycle", o_ready, 0);
        tick();
        check("t2_accept", o_ready, 1);
        set_st(0, 0, 0, `W_MODE);
        for (int i = 0; i < 6; i++) tick();

        // Byte store hazards a word load; drain proceeds during the stall
        set_st(1, 32'h1003, 32'hAB, `B_MODE);
        tick();
        set_st(0, 0, 0, `W_MODE);
        set_ld(1, 32'h1000, `W_MODE);
        tick();
        check("t3_stall", o_stall, 1);
        check("t3_drain", o_we, 1);
        tick();
        check("t3_release", o_stall, 0);
        set_ld(0, 0, `W_MODE);
        tick();

        // Two full-word stores to the same word, then a word load
        set_ld(1, 32'h80, `W_MODE);
        set_st(1, 32'h40, 32'h1111_1111, `W_MODE);
        tick();
        set_st(1, 32'h40, 32'h2222_2222, `W_MODE);
        tick();
        set_st(0, 0, 0, `W_MODE);
        set_ld(1, 32'h40, `W_MODE);
        tick();
`ifdef STB_FWD_EN
        check("t4_fv", o_fv, 1);
        check("t4_fd", o_fd, 32'h2222_2222);
        check("t4_stall", o_stall, 0);
`else
        check("t4_fv", o_fv, 0);
        check("t4_stall", o_stall, 1);
`endif
        set_ld(0, 0, `W_MODE);
        for (int i = 0; i < 3; i++) tick();

        // Misaligned half store is dropped with a one-cycle pulse
        set_st(1, 32'h301, 32'h1234, `H_MODE);
        tick();
        set_st(0, 0, 0, `W_MODE);
        tick();
        check("t5_pulse", o_mis, 1);
        check("t5_empty", o_empty, 1);
        tick();
        check("t5_pulse_end", o_mis, 0);

        // Reset mid-drain discards everything
        set_ld(1, 32'h200, `W_MODE);
        for (int i = 0; i < 3; i++) begin
            set_st(1, 32'h600 + 32'(4 * i), 32'hC0 + 32'(i), `W_MODE);
            tick();
        end
        set_st(0, 0, 0, `W_MODE);
        set_ld(0, 0, `W_MODE);
        tick();
        check("t6_drain", o_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we_cyc.delete(); we_addr.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_empty", o_empty, 1);
        end
        check("t6_nwrites", we_cyc.size(), 0);

        // Random traffic over a small address window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            logic [2:0] sm, lm;
            sm = (($urandom_range(0, 2) == 0) ? `B_MODE : (($urandom_range(0, 1) == 0) ? `H_MODE : `W_MODE));
            lm = (($urandom_range(0, 2) == 0) ? `B_MODE : (($urandom_range(0, 1) == 0) ? `H_MODE : `W_MODE));
            set_st($urandom_range(0, 1) == 1, {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                   $urandom, sm);
            set_ld($urandom_range(0, 2) != 0, {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, lm);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
